keypad_scanner: RTL



---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_debounce.sv | 33 +++
 rtl/keypad_scanner.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_COL  = 1'b1
    } scan_phase_t;

    // Wide enough for any keypad whose frame fits the popcount helper below.
    localparam int unsigned EV_CODE_W = 8;
    localparam int unsigned POP_W_MAX = 256;

    typedef struct packed {
        logic [EV_CODE_W-1:0] code;
        logic                 press;
    } key_event_t;

    function automatic int unsigned popcount(input logic [POP_W_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W_MAX; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    function automatic int unsigned calc_stable_cycles(input int unsigned clk_freq,
                                                       input int unsigned stable_ms);
        return clk_freq / 1000 * stable_ms;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Single-key debouncer: output follows input after it has held a new level long enough.
module keypad_debounce #(
    parameter int unsigned stable_cycles = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int unsigned     CNT_W    = $clog2(stable_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(stable_cycles - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic             dout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            dout_reg <= 1'b0;
        end else if (din == dout_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            dout_reg <= din;
            cnt_reg  <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column scan, ghost-frame rejection, per-key debounce
// and a first-word-fall-through press/release event FIFO.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned clk_freq      = 50_000_000,
    parameter int unsigned stable_ms     = 10,
    parameter int unsigned n_rows        = 4,
    parameter int unsigned n_cols        = 4,
    parameter int unsigned settle_cycles = 16,
    parameter int unsigned max_keys      = 1,
    parameter int unsigned fifo_depth    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [n_rows-1:0]                  row,
    output logic [n_cols-1:0]                  col,
    output logic [n_rows*n_cols-1:0]           keys,
    output logic                               ev_valid,
    input  logic                               ev_ready,
    output logic [$clog2(n_rows*n_cols)-1:0]   ev_code,
    output logic                               ev_press
);
    localparam int unsigned N_KEYS = n_rows * n_cols;
    localparam int unsigned CODE_W = $clog2(N_KEYS);
    localparam int unsigned STABLE = calc_stable_cycles(clk_freq, stable_ms);
    localparam int unsigned SET_W  = $clog2(settle_cycles);
    localparam int unsigned CIDX_W = (n_cols > 1) ? $clog2(n_cols) : 1;
    localparam int unsigned PTR_W  = $clog2(fifo_depth);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(settle_cycles - 1);
    localparam logic [SET_W-1:0]  SET_ONE  = SET_W'(1);
    localparam logic [CIDX_W-1:0] COL_LAST = CIDX_W'(n_cols - 1);
    localparam logic [CIDX_W-1:0] CIDX_ONE = CIDX_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(fifo_depth);

    logic [n_rows-1:0] row_meta_reg;
    logic [n_rows-1:0] row_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_reg <= '1;
            row_sync_reg <= '1;
        end else begin
            row_meta_reg <= row;
            row_sync_reg <= row_meta_reg;
        end
    end

    // Scan FSM
    scan_phase_t       phase_reg, phase_next;
    logic [CIDX_W-1:0] col_idx_reg, col_idx_next;
    logic [SET_W-1:0]  settle_reg, settle_next;
    logic              phase_last;

    assign phase_last = (settle_reg == SET_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg   <= PH_IDLE;
            col_idx_reg <= '0;
            settle_reg  <= '0;
        end else begin
            phase_reg   <= phase_next;
            col_idx_reg <= col_idx_next;
            settle_reg  <= settle_next;
        end
    end

    always_comb begin
        phase_next   = phase_reg;
        col_idx_next = col_idx_reg;
        settle_next  = phase_last ? '0 : settle_reg + SET_ONE;
        if (phase_last) begin
            case (phase_reg)
                PH_IDLE: begin
                    phase_next   = PH_COL;
                    col_idx_next = '0;
                end
                PH_COL: begin
                    if (col_idx_reg == COL_LAST) begin
                        phase_next   = PH_IDLE;
                        col_idx_next = '0;
                    end else begin
                        col_idx_next = col_idx_reg + CIDX_ONE;
                    end
                end
                default: phase_next = PH_IDLE;
            endcase
        end
    end

    always_comb begin
        col = '1;
        for (int c = 0; c < n_cols; c++) begin
            col[c] = !((phase_reg == PH_COL) && (col_idx_reg == CIDX_W'(c)));
        end
    end

    // Raw frame assembly; frames with too many keys are treated as ghosting and dropped.
    logic [N_KEYS-1:0] raw_reg;
    logic [N_KEYS-1:0] frame_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_reg   <= '0;
            frame_reg <= '0;
        end else if (phase_last) begin
            if (phase_reg == PH_IDLE) begin
                if (popcount(POP_W_MAX'(raw_reg)) <= max_keys) begin
                    frame_reg <= raw_reg;
                end
                raw_reg <= '0;
            end else begin
                for (int r = 0; r < n_rows; r++) begin
                    for (int c = 0; c < n_cols; c++) begin
                        if (col_idx_reg == CIDX_W'(c)) begin
                            raw_reg[r*n_cols+c] <= ~row_sync_reg[r];
                        end
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        keypad_debounce #(
            .stable_cycles(STABLE)
        ) u_debounce (
            .clk (clk),
            .rst (rst),
            .din (frame_reg[gi]),
            .dout(keys[gi])
        );
    end

    // Event generation: report the lowest-index key whose level differs from what was last reported.
    logic [N_KEYS-1:0] keys_dly_reg;
    logic [N_KEYS-1:0] reported_reg;
    logic [N_KEYS-1:0] diff;
    logic [CODE_W-1:0] low_idx;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    key_event_t        push_ev;
    key_event_t        head;

    assign diff = keys_dly_reg ^ reported_reg;

    always_comb begin
        low_idx = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (diff[k]) begin
                low_idx = CODE_W'(k);
            end
        end
    end

    assign push = (diff != '0) && !full;

    always_comb begin
        push_ev       = '0;
        push_ev.code  = EV_CODE_W'(low_idx);
        push_ev.press = keys_dly_reg[low_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keys_dly_reg <= '0;
            reported_reg <= '0;
        end else begin
            keys_dly_reg <= keys;
            if (push) begin
                reported_reg[low_idx] <= keys_dly_reg[low_idx];
            end
        end
    end

    key_event_t       fifo_mem [fifo_depth];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);
    assign pop   = !empty && ev_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head     = fifo_mem[rd_ptr_reg];
    assign ev_valid = !empty;
    assign ev_code  = empty ? '0 : head.code[CODE_W-1:0];
    assign ev_press = !empty && head.press;

    if (CODE_W < EV_CODE_W) begin : g_code_pad
        logic unused_code_bits;
        assign unused_code_bits = ^head.code[EV_CODE_W-1:CODE_W];
    end

endmodule
